seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring radix-2 divider, one quotient bit per clock.
// Optional build macro SEQ_DIVIDER_SIGNED_EN switches to two's-complement operands
// (the core divides magnitudes; the quotient truncates toward zero and the
// remainder takes the dividend's sign). Without the macro everything is unsigned.
//
// Handshake: start is sampled only while the FSM is IDLE (ignored while busy).
// busy rises on the sampling edge and falls on the edge that raises done.
// done is a single-cycle pulse; out/rem/div_by_zero are valid with it and hold
// their values until the next completion. state_dbg mirrors the FSM state.
module seq_divider #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [DATA_LEN-1:0] in1,
  input  logic [DATA_LEN-1:0] in2,
  output logic [DATA_LEN-1:0] out,
  output logic [DATA_LEN-1:0] rem,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [1:0]          state_dbg
);

  localparam int CW = (DATA_LEN > 2) ? $clog2(DATA_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_LEN-1:0] dvd;   // dividend magnitude, shifted out MSB-first
  logic [DATA_LEN-1:0] dvs;   // divisor magnitude
  logic [DATA_LEN-1:0] acc;   // partial remainder (always < dvs)
  logic [DATA_LEN-1:0] quo;   // quotient magnitude, shifted in LSB-first

  // One extra bit on the trial remainder so a divisor with its MSB set
  // can never wrap the subtraction.
  logic [DATA_LEN:0]   acc_sh;
  logic [DATA_LEN:0]   acc_sub;
  logic                borrow;

  logic [DATA_LEN-1:0] mag1;
  logic [DATA_LEN-1:0] mag2;
  logic [DATA_LEN-1:0] q_fin;
  logic [DATA_LEN-1:0] r_fin;
  logic [DATA_LEN-1:0] dvd_orig;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;  // quotient must be negated at the end
  logic neg_r;  // remainder (and original dividend) is negative

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // exactly its unsigned magnitude.
  always_comb begin
    mag1 = in1[DATA_LEN-1] ? -in1 : in1;
    mag2 = in2[DATA_LEN-1] ? -in2 : in2;
  end

  // Re-apply signs to the magnitude results.
  always_comb begin
    q_fin    = neg_q ? -quo : quo;
    r_fin    = neg_r ? -acc : acc;
    dvd_orig = neg_r ? -dvd : dvd;
  end
`else
  // Unsigned: operands and results pass straight through.
  always_comb begin
    mag1     = in1;
    mag2     = in2;
    q_fin    = quo;
    r_fin    = acc;
    dvd_orig = dvd;
  end
`endif

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    acc_sh  = {acc, dvd[DATA_LEN-1]};
    acc_sub = acc_sh - {1'b0, dvs};
    borrow  = acc_sub[DATA_LEN];
  end

  assign state_dbg = state;

  // Control FSM plus datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      acc         <= '0;
      quo         <= '0;
      out         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= mag1;
            dvs   <= mag2;
            acc   <= '0;
            quo   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= in1[DATA_LEN-1] ^ in2[DATA_LEN-1];
            neg_r <= in1[DATA_LEN-1];
`endif
            // A zero divisor skips the iteration entirely.
            state <= (in2 == '0) ? FINISH : CALC;
          end
        end
        CALC: begin
          dvd <= {dvd[DATA_LEN-2:0], 1'b0};
          acc <= borrow ? acc_sh[DATA_LEN-1:0] : acc_sub[DATA_LEN-1:0];
          quo <= {quo[DATA_LEN-2:0], ~borrow};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DATA_LEN - 1)) state <= FINISH;
        end
        FINISH: begin
          // dvs is zero exactly when the latched divisor was zero.
          if (dvs == '0) begin
            out         <= '1;
            rem         <= dvd_orig;
            div_by_zero <= 1'b1;
          end else begin
            out         <= q_fin;
            rem         <= r_fin;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
